icache_refill: RTL and testbench



---
 rtl/cpu_defs.sv | 13 +
 rtl/refill_byte_pack.sv | 20 ++
 rtl/icache_refill.sv | 130 +++++++++++++
 tb/tb_icache_refill.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared CPU constants and refill state encoding
package cpu_defs;
  localparam int INST_ADDR_W    = 32;
  localparam int BYTES_PER_INST = 4;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DONE,
    DRAIN
  } refill_state_t;
endpackage

// File: rtl/refill_byte_pack.sv
// rtl/refill_byte_pack.sv - little-endian byte-lane assembler for a 32-bit word
module refill_byte_pack (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clr,
  input  logic [1:0]  idx,
  input  logic [7:0]  data,
  output logic [31:0] word
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      word <= '0;
    end else if (en) begin
      word[{idx, 3'b000} +: 8] <= data;
    end
  end

endmodule

// File: rtl/icache_refill.sv
// rtl/icache_refill.sv - icache miss handler: byte-wide refill of one instruction word
module icache_refill
  import cpu_defs::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   fetch_req_i,
  input  logic [INST_ADDR_W-1:0] pc_i,
  input  logic                   flush_i,
  input  logic                   hit_i,
  input  logic [31:0]            inst_i,
  output logic                   inst_valid_o,
  output logic [31:0]            inst_o,
  output logic                   we_o,
  output logic [INST_ADDR_W-1:0] waddr_o,
  output logic [31:0]            winst_o,
  output logic                   mem_req_o,
  output logic [INST_ADDR_W-1:0] mem_addr_o,
  input  logic                   mem_gnt_i,
  input  logic                   mem_valid_i,
  input  logic [7:0]             mem_data_i
);

  localparam logic [2:0] LAST = 3'(BYTES_PER_INST);

  refill_state_t              state, state_n;
  logic [INST_ADDR_W-1:2]     line_addr, line_addr_n;
  logic [2:0]                 issue_cnt, issue_n;
  logic [2:0]                 recv_cnt, recv_n;
  logic [31:0]                word;
  logic                       pack_en, pack_clr;
  logic [INST_ADDR_W-1:0]     base;
  logic                       unused_pc_lsb;

  assign base          = {line_addr, 2'b00};
  assign unused_pc_lsb = ^pc_i[1:0];

  refill_byte_pack u_pack (
    .clk  (clk),
    .rst  (rst),
    .en   (pack_en),
    .clr  (pack_clr),
    .idx  (recv_cnt[1:0]),
    .data (mem_data_i),
    .word (word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      line_addr <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
    end else if (rdy) begin
      state     <= state_n;
      line_addr <= line_addr_n;
      issue_cnt <= issue_n;
      recv_cnt  <= recv_n;
    end
  end

  always_comb begin
    state_n      = state;
    line_addr_n  = line_addr;
    issue_n      = issue_cnt;
    recv_n       = recv_cnt;
    pack_en      = 1'b0;
    pack_clr     = 1'b0;
    inst_valid_o = 1'b0;
    inst_o       = '0;
    we_o         = 1'b0;
    mem_req_o    = 1'b0;
    mem_addr_o   = base + 32'(issue_cnt);
    waddr_o      = base;
    winst_o      = word;

    unique case (state)
      IDLE: begin
        if (fetch_req_i && hit_i) begin
          inst_valid_o = 1'b1;
          inst_o       = inst_i;
        end
        if (fetch_req_i && !hit_i && !flush_i) begin
          line_addr_n = pc_i[INST_ADDR_W-1:2];
          issue_n     = '0;
          recv_n      = '0;
          pack_clr    = 1'b1;
          state_n     = REQ;
        end
      end
      REQ, WAIT: begin
        mem_req_o = (state == REQ) && !flush_i;
        if (mem_req_o && mem_gnt_i) issue_n = issue_cnt + 3'd1;
        if (mem_valid_i) begin
          pack_en = 1'b1;
          recv_n  = recv_cnt + 3'd1;
        end
        // Counts include this cycle's grant/return so nothing in flight is lost.
        if (flush_i)               state_n = (issue_n > recv_n) ? DRAIN : IDLE;
        else if (recv_n == LAST)   state_n = DONE;
        else if (issue_n == LAST)  state_n = WAIT;
      end
      DONE: begin
        if (!flush_i) begin
          we_o = 1'b1;
          if (fetch_req_i && pc_i[INST_ADDR_W-1:2] == line_addr) begin
            inst_valid_o = 1'b1;
            inst_o       = word;
          end
        end
        state_n = IDLE;
      end
      DRAIN: begin
        if (mem_valid_i) recv_n = recv_cnt + 3'd1;
        if (recv_n == issue_cnt) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (!rdy) begin
      mem_req_o    = 1'b0;
      inst_valid_o = 1'b0;
      we_o         = 1'b0;
      pack_en      = 1'b0;
      pack_clr     = 1'b0;
    end
  end

endmodule

// File: tb/tb_icache_refill.sv
// tb/tb_icache_refill.sv - directed self-checking bench for icache_refill
module tb_icache_refill;

  logic        clk, rst, rdy;
  logic        fetch_req, flush, hit;
  logic [31:0] pc, inst_in;
  logic        inst_valid, we, mem_req, mem_gnt, mem_valid;
  logic [31:0] inst_out, waddr, winst, mem_addr;
  logic [7:0]  mem_data;

  int n_cmp = 0;
  int n_err = 0;

  icache_refill dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .fetch_req_i  (fetch_req),
    .pc_i         (pc),
    .flush_i      (flush),
    .hit_i        (hit),
    .inst_i       (inst_in),
    .inst_valid_o (inst_valid),
    .inst_o       (inst_out),
    .we_o         (we),
    .waddr_o      (waddr),
    .winst_o      (winst),
    .mem_req_o    (mem_req),
    .mem_addr_o   (mem_addr),
    .mem_gnt_i    (mem_gnt),
    .mem_valid_i  (mem_valid),
    .mem_data_i   (mem_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic f, input logic [31:0] p, input logic h,
                       input logic g, input logic v, input logic [7:0] d);
    fetch_req = f;
    pc        = p;
    hit       = h;
    mem_gnt   = g;
    mem_valid = v;
    mem_data  = d;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Miss at cycle 0, grants every cycle, bytes one cycle after each grant, DONE at cycle 6.
  task automatic run_full(input string tag, input logic [31:0] p, input logic [31:0] w,
                          input logic [31:0] pc_done);
    logic [31:0] aligned;
    logic        match;
    aligned = {p[31:2], 2'b00};
    match   = (pc_done[31:2] == p[31:2]);
    drive(1, p, 0, 0, 0, 8'h00);
    check({tag, "_c0_req"}, 32'(mem_req), 32'd0);
    tick;
    for (int i = 0; i < 4; i++) begin
      drive(1, p, 0, 1, i > 0, (i > 0) ? w[8*(i-1) +: 8] : 8'h00);
      check($sformatf("%s_c%0d_req", tag, i + 1), 32'(mem_req), 32'd1);
      check($sformatf("%s_c%0d_addr", tag, i + 1), mem_addr, aligned + 32'(i));
      tick;
    end
    drive(1, p, 0, 0, 1, w[31:24]);
    check({tag, "_c5_req"}, 32'(mem_req), 32'd0);
    check({tag, "_c5_we"}, 32'(we), 32'd0);
    tick;
    drive(1, pc_done, 0, 0, 0, 8'h00);
    check({tag, "_done_we"}, 32'(we), 32'd1);
    check({tag, "_done_waddr"}, waddr, aligned);
    check({tag, "_done_winst"}, winst, w);
    check({tag, "_done_ivalid"}, 32'(inst_valid), 32'(match));
    if (match) check({tag, "_done_inst"}, inst_out, w);
    tick;
    drive(0, 0, 0, 0, 0, 8'h00);
    check({tag, "_after_we"}, 32'(we), 32'd0);
    check({tag, "_after_ivalid"}, 32'(inst_valid), 32'd0);
  endtask

  initial begin
    clk = 0; rst = 1; rdy = 1; flush = 0; inst_in = 32'h0;
    drive(0, 0, 0, 0, 0, 8'h00);
    tick;
    tick;
    rst = 0;
    check("rst_ivalid", 32'(inst_valid), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_winst", winst, 32'h0);

    // Hit delivered combinationally, no memory traffic.
    inst_in = 32'h0000_0013;
    drive(1, 32'h100, 1, 0, 0, 8'h00);
    check("hit_ivalid", 32'(inst_valid), 32'd1);
    check("hit_inst", inst_out, 32'h0000_0013);
    check("hit_req", 32'(mem_req), 32'd0);
    tick;
    drive(0, 0, 0, 0, 0, 8'h00);
    check("hit_next_req", 32'(mem_req), 32'd0);
    tick;

    // Miss under flush in IDLE starts nothing.
    flush = 1;
    drive(1, 32'h600, 0, 0, 0, 8'h00);
    tick;
    flush = 0;
    drive(0, 0, 0, 0, 0, 8'h00);
    check("flush_idle_req", 32'(mem_req), 32'd0);
    tick;

    run_full("full", 32'h200, 32'h0010_0093, 32'h200);
    tick;

    // Grant stall: unaligned pc, grants withheld in cycles 2-3.
    drive(1, 32'h203, 0, 0, 0, 8'h00); tick;
    drive(1, 32'h203, 0, 1, 0, 8'h00);
    check("stall_c1_addr", mem_addr, 32'h200); tick;
    drive(1, 32'h203, 0, 0, 1, 8'h93);
    check("stall_c2_req", 32'(mem_req), 32'd1);
    check("stall_c2_addr", mem_addr, 32'h201); tick;
    drive(1, 32'h203, 0, 0, 0, 8'h00);
    check("stall_c3_req", 32'(mem_req), 32'd1);
    check("stall_c3_addr", mem_addr, 32'h201); tick;
    drive(1, 32'h203, 0, 1, 0, 8'h00);
    check("stall_c4_addr", mem_addr, 32'h201); tick;
    drive(1, 32'h203, 0, 1, 1, 8'h00);
    check("stall_c5_addr", mem_addr, 32'h202); tick;
    drive(1, 32'h203, 0, 1, 1, 8'h10);
    check("stall_c6_addr", mem_addr, 32'h203); tick;
    drive(1, 32'h203, 0, 0, 1, 8'h00);
    check("stall_c7_we", 32'(we), 32'd0); tick;
    drive(1, 32'h203, 0, 0, 0, 8'h00);
    check("stall_c8_we", 32'(we), 32'd1);
    check("stall_c8_waddr", waddr, 32'h200);
    check("stall_c8_winst", winst, 32'h0010_0093);
    check("stall_c8_ivalid", 32'(inst_valid), 32'd1); tick;

    // Flush after 2 grants and 1 byte: drain the second byte, no write.
    drive(1, 32'h200, 0, 0, 0, 8'h00); tick;
    drive(0, 0, 0, 1, 0, 8'h00); tick;
    drive(0, 0, 0, 1, 1, 8'h93); tick;
    flush = 1;
    drive(0, 0, 0, 1, 0, 8'h00);
    check("flush_c3_req", 32'(mem_req), 32'd0); tick;
    flush = 0;
    drive(0, 0, 0, 0, 1, 8'h00);
    check("drain_req", 32'(mem_req), 32'd0);
    check("drain_we", 32'(we), 32'd0); tick;
    run_full("post_flush", 32'h300, 32'h0030_0513, 32'h300);
    tick;

    // rdy low for 3 cycles in WAIT delays DONE from cycle 6 to cycle 9.
    drive(1, 32'h200, 0, 0, 0, 8'h00); tick;
    drive(1, 32'h200, 0, 1, 0, 8'h00); tick;
    drive(1, 32'h200, 0, 1, 1, 8'h93); tick;
    drive(1, 32'h200, 0, 1, 1, 8'h00); tick;
    drive(1, 32'h200, 0, 1, 1, 8'h10); tick;
    rdy = 0;
    for (int i = 5; i < 8; i++) begin
      drive(1, 32'h200, 0, 0, 0, 8'h00);
      check($sformatf("pause_c%0d_req", i), 32'(mem_req), 32'd0);
      check($sformatf("pause_c%0d_we", i), 32'(we), 32'd0);
      tick;
    end
    rdy = 1;
    drive(1, 32'h200, 0, 0, 1, 8'h00);
    check("pause_c8_we", 32'(we), 32'd0); tick;
    drive(1, 32'h200, 0, 0, 0, 8'h00);
    check("pause_c9_we", 32'(we), 32'd1);
    check("pause_c9_winst", winst, 32'h0010_0093);
    check("pause_c9_ivalid", 32'(inst_valid), 32'd1);
    check("pause_c9_inst", inst_out, 32'h0010_0093); tick;
    drive(0, 0, 0, 0, 0, 8'h00);
    check("pause_c10_we", 32'(we), 32'd0); tick;

    // Reset during REQ abandons the refill.
    drive(1, 32'h400, 0, 0, 0, 8'h00); tick;
    drive(1, 32'h400, 0, 1, 0, 8'h00);
    check("mrst_c1_addr", mem_addr, 32'h400); tick;
    rst = 1;
    drive(0, 0, 0, 1, 0, 8'h00); tick;
    rst = 0;
    drive(0, 0, 0, 0, 0, 8'h00);
    check("mrst_req", 32'(mem_req), 32'd0);
    check("mrst_addr", mem_addr, 32'h0);
    check("mrst_waddr", waddr, 32'h0);
    check("mrst_winst", winst, 32'h0);
    check("mrst_we", 32'(we), 32'd0);
    check("mrst_ivalid", 32'(inst_valid), 32'd0);
    check("mrst_inst", inst_out, 32'h0); tick;
    run_full("post_rst", 32'h500, 32'hdead_beef, 32'h504);
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
